rr_req_arbiter: RTL and testbench

Registered request-capture and round-robin arbitration stage that sits directly downstream of the request-vector producer. It also wraps priority-encode logic of the style used by the combinational priority encoder.
- Latches per-line request pulses into a sticky pending vector.
- Selects one pending line per cycle with rotating priority.
- Presents the winner as a binary index plus one-hot grant on a valid/ready handshake.
- Clears the pending bit only on handshake acceptance.

---
 rtl/rr_req_arbiter_if.sv | 33 +++
 rtl/rr_req_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_req_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle for rr_req_arbiter.
// The slave modport is the arbiter side; the master modport is the
// producer/consumer side that drives requests and out_ready.
interface rr_req_arbiter_if #(
  parameter int IN_WIDTH = 8
);
  localparam int OUT_WIDTH = $clog2(IN_WIDTH);

  logic [IN_WIDTH-1:0]  req_in;
  logic                 out_ready;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_idx;
  logic [IN_WIDTH-1:0]  out_grant;
  logic [IN_WIDTH-1:0]  pending;

  modport master (
    output req_in,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_grant,
    input  pending
  );

  modport slave (
    input  req_in,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_grant,
    output pending
  );
endinterface

// File: rtl/rr_req_arbiter.sv
// Registered request capture plus round-robin arbiter.
// Request pulses are held in a sticky pending vector; one pending line is
// offered per cycle on a valid/ready handshake and its bit is cleared only
// when the offer is accepted. All outputs come straight from registers.
// Optional macro RR_ARB_FIXED_PRIO_EN: highest-index pending line always
// wins and the rotating pointer is removed.
module rr_req_arbiter #(
  parameter int IN_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  rr_req_arbiter_if.slave  bus
);
  localparam int OUT_WIDTH = $clog2(IN_WIDTH);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t               state_p0;
  state_t               state_nx;
  logic [IN_WIDTH-1:0]  pend_p0;
  logic [OUT_WIDTH-1:0] idx_p0;
  logic [IN_WIDTH-1:0]  grant_p0;

  logic                 acc;
  logic                 load;
  logic [IN_WIDTH-1:0]  pend_nx;
  logic [OUT_WIDTH-1:0] win_idx;

`ifndef RR_ARB_FIXED_PRIO_EN
  logic [OUT_WIDTH-1:0] ptr_p0;
  logic [OUT_WIDTH-1:0] ptr_nx;

  // Rotating-priority pick: duplicate the vector, mask the low copy below
  // start, take the lowest surviving bit and fold it back into range.
  function automatic logic [OUT_WIDTH-1:0] rr_pick(
    input logic [IN_WIDTH-1:0]  vec,
    input logic [OUT_WIDTH-1:0] start
  );
    logic [2*IN_WIDTH-1:0] dbl;
    int                    sel;
    dbl = {vec, vec};
    sel = 0;
    for (int i = 2*IN_WIDTH-1; i >= 0; i--) begin
      if (dbl[i] && (i >= int'(start))) sel = i;
    end
    if (sel >= IN_WIDTH) sel = sel - IN_WIDTH;
    return OUT_WIDTH'(sel);
  endfunction
`else
  // Fixed-priority pick: highest set index wins.
  function automatic logic [OUT_WIDTH-1:0] fixed_pick(
    input logic [IN_WIDTH-1:0] vec
  );
    int sel;
    sel = 0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (vec[i]) sel = i;
    end
    return OUT_WIDTH'(sel);
  endfunction
`endif

  // Binary index to one-hot.
  function automatic logic [IN_WIDTH-1:0] to_onehot(
    input logic [OUT_WIDTH-1:0] idx
  );
    logic [IN_WIDTH-1:0] g;
    for (int i = 0; i < IN_WIDTH; i++) begin
      g[i] = (int'(idx) == i);
    end
    return g;
  endfunction

  // Handshake, pending update, winner selection and next state.
  always_comb begin
    acc      = (state_p0 == OFFER) && bus.out_ready;
    pend_nx  = (pend_p0 & ~(acc ? grant_p0 : '0)) | bus.req_in;
    load     = ((state_p0 == IDLE) || acc) && (pend_nx != '0);
`ifndef RR_ARB_FIXED_PRIO_EN
    ptr_nx   = ptr_p0;
    if (acc) begin
      ptr_nx = (int'(idx_p0) == IN_WIDTH-1) ? '0 : idx_p0 + OUT_WIDTH'(1);
    end
    win_idx  = rr_pick(pend_nx, ptr_nx);
`else
    win_idx  = fixed_pick(pend_nx);
`endif
    state_nx = state_p0;
    if ((state_p0 == IDLE) || acc) begin
      state_nx = (pend_nx != '0) ? OFFER : IDLE;
    end
  end

  // ---- stage p0: state, pending vector, offered winner, pointer ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      pend_p0  <= '0;
      idx_p0   <= '0;
      grant_p0 <= '0;
`ifndef RR_ARB_FIXED_PRIO_EN
      ptr_p0   <= '0;
`endif
    end else begin
      state_p0 <= state_nx;
      pend_p0  <= pend_nx;
      if (load) begin
        idx_p0   <= win_idx;
        grant_p0 <= to_onehot(win_idx);
      end
`ifndef RR_ARB_FIXED_PRIO_EN
      ptr_p0   <= ptr_nx;
`endif
    end
  end

  // Outputs are decoded only from registered state.
  always_comb begin
    bus.out_valid = (state_p0 == OFFER);
    bus.out_idx   = idx_p0;
    bus.out_grant = (state_p0 == OFFER) ? grant_p0 : '0;
    bus.pending   = pend_p0;
  end
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Bench for rr_req_arbiter: table of directed vectors, a reset-mid-offer
// sequence and randomized traffic against a behavioural model.
module tb_rr_req_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  rr_req_arbiter_if #(.IN_WIDTH(W)) bus ();

  rr_req_arbiter #(.IN_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic         m_valid;
  int           m_idx;
  int           m_ptr;
  logic [W-1:0] m_pend;

  typedef struct {
    logic         r;
    logic [W-1:0] q;
    logic         rdy;
    logic         ev;
    int           ei;
    logic [W-1:0] eg;
    logic [W-1:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [W-1:0] q, input logic rdy,
                              input logic ev, input int ei, input logic [W-1:0] eg,
                              input logic [W-1:0] ep);
    vec_t v;
    v.r = r; v.q = q; v.rdy = rdy; v.ev = ev; v.ei = ei; v.eg = eg; v.ep = ep;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Winner chosen from the rules: scan upward from the pointer with wrap,
  // or take the highest set bit in fixed-priority builds.
  function automatic int model_pick(input logic [W-1:0] v, input int p);
    int w;
    w = 0;
`ifndef RR_ARB_FIXED_PRIO_EN
    for (int k = W-1; k >= 0; k--) begin
      if (v[(p + k) % W]) w = (p + k) % W;
    end
`else
    for (int k = 0; k < W; k++) begin
      if (v[k]) w = k;
    end
`endif
    return w;
  endfunction

  task automatic model_update(input logic r, input logic [W-1:0] q, input logic rdy);
    logic         acc;
    logic [W-1:0] pn;
    if (r) begin
      m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_pend = '0;
    end else begin
      acc = m_valid && rdy;
      pn  = m_pend;
      if (acc) begin
        pn[m_idx] = 1'b0;
        m_ptr     = (m_idx + 1) % W;
      end
      pn = pn | q;
      if (!m_valid || acc) begin
        if (pn != '0) begin
          m_valid = 1'b1;
          m_idx   = model_pick(pn, m_ptr);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = pn;
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] q, input logic rdy);
    logic [W-1:0] g;
    rst = r; bus.req_in = q; bus.out_ready = rdy;
    @(posedge clk);
    model_update(r, q, rdy);
    #1;
    g = '0;
    if (m_valid) g[m_idx] = 1'b1;
    check("valid", bus.out_valid, m_valid);
    check("grant", bus.out_grant, g);
    check("pending", bus.pending, m_pend);
    if (m_valid) check("idx", bus.out_idx, m_idx);
    check("onehot", ($countones(bus.out_grant) <= 1), 1);
    check("subset", ((bus.out_grant & ~bus.pending) == '0), 1);
  endtask

  initial begin
    rst = 1'b1; bus.req_in = '0; bus.out_ready = 1'b0;
    m_valid = 1'b0; m_idx = 0; m_ptr = 0; m_pend = '0;

`ifndef RR_ARB_FIXED_PRIO_EN
    // reset held with requests present, then released idle
    add(1, 8'hFF, 1, 0, 0, 8'h00, 8'h00);
    add(1, 8'hFF, 1, 0, 0, 8'h00, 8'h00);
    add(1, 8'hFF, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // single pulse on line 4
    add(0, 8'h10, 1, 1, 4, 8'h10, 8'h10);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // all lines from ptr=0: 0..7 back to back
    add(1, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'hFF, 1, 1, 0, 8'h01, 8'hFF);
    add(0, 8'h00, 1, 1, 1, 8'h02, 8'hFE);
    add(0, 8'h00, 1, 1, 2, 8'h04, 8'hFC);
    add(0, 8'h00, 1, 1, 3, 8'h08, 8'hF8);
    add(0, 8'h00, 1, 1, 4, 8'h10, 8'hF0);
    add(0, 8'h00, 1, 1, 5, 8'h20, 8'hE0);
    add(0, 8'h00, 1, 1, 6, 8'h40, 8'hC0);
    add(0, 8'h00, 1, 1, 7, 8'h80, 8'h80);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // backpressure holds the offer; then 3, then wrap to 0
    add(1, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h0A, 0, 1, 1, 8'h02, 8'h0A);
    add(0, 8'h01, 0, 1, 1, 8'h02, 8'h0B);
    add(0, 8'h00, 0, 1, 1, 8'h02, 8'h0B);
    add(0, 8'h01, 0, 1, 1, 8'h02, 8'h0B);
    add(0, 8'h00, 0, 1, 1, 8'h02, 8'h0B);
    add(0, 8'h80, 0, 1, 1, 8'h02, 8'h8B);
    add(0, 8'h00, 1, 1, 3, 8'h08, 8'h89);
    add(0, 8'h00, 1, 1, 7, 8'h80, 8'h81);
    add(0, 8'h00, 1, 1, 0, 8'h01, 8'h01);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    // collision: accepted bit re-requested stays pending, re-offered after wrap
    add(1, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    add(0, 8'h0C, 0, 1, 2, 8'h04, 8'h0C);
    add(0, 8'h04, 1, 1, 3, 8'h08, 8'h0C);
    add(0, 8'h00, 1, 1, 2, 8'h04, 8'h04);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
`else
    add(1, 8'hFF, 1, 0, 0, 8'h00, 8'h00);
    add(1, 8'hFF, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'h81, 1, 1, 7, 8'h80, 8'h81);
    add(0, 8'h00, 1, 1, 0, 8'h01, 8'h01);
    add(0, 8'h81, 1, 1, 7, 8'h80, 8'h81);
    add(0, 8'h00, 1, 1, 0, 8'h01, 8'h01);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
    add(0, 8'h24, 0, 1, 5, 8'h20, 8'h24);
    add(0, 8'h80, 0, 1, 5, 8'h20, 8'hA4);
    add(0, 8'h00, 1, 1, 7, 8'h80, 8'h84);
    add(0, 8'h00, 1, 1, 2, 8'h04, 8'h04);
    add(0, 8'h00, 1, 0, 0, 8'h00, 8'h00);
`endif

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].rdy);
      check($sformatf("row%0d_valid", i), bus.out_valid, tbl[i].ev);
      check($sformatf("row%0d_grant", i), bus.out_grant, tbl[i].eg);
      check($sformatf("row%0d_pending", i), bus.pending, tbl[i].ep);
      if (tbl[i].ev || tbl[i].r) check($sformatf("row%0d_idx", i), bus.out_idx, tbl[i].ei);
    end

    // reset in the middle of an offer drops offer and pending lines
    step(0, 8'h3C, 0);
    step(0, 8'h00, 0);
    step(1, 8'hFF, 1);
    check("rstmid_valid", bus.out_valid, 1'b0);
    check("rstmid_pending", bus.pending, 8'h00);
    check("rstmid_idx", bus.out_idx, 0);
    step(0, 8'h00, 1);
    check("rstmid_after", bus.out_valid, 1'b0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic         r;
      logic [W-1:0] q;
      logic         rdy;
      r   = ($urandom_range(0, 199) == 0);
      q   = W'($urandom & $urandom);
      if ($urandom_range(0, 2) == 0) q = '0;
      rdy = ($urandom_range(0, 3) != 0);
      step(r, q, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
